// File: rtl/rename_map_table_pkg.sv
// Shared widths and allocator state encoding for the rename stage and the
// physical-register free list.
package rename_map_table_pkg;
    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHYS_REGS = 64;
    localparam int LOG_ARCH      = $clog2(NUM_ARCH_REGS);
    localparam int LOG_PHYS      = $clog2(NUM_PHYS_REGS);

    typedef logic [LOG_ARCH-1:0] arch_t;
    typedef logic [LOG_PHYS-1:0] phys_t;

    localparam logic [1:0] ST_NEED    = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_HAVE    = 2'd2;
endpackage

// File: rtl/rename_map_table_if.sv
// Rename-stage signal bundle: decode handshake, free-list dequeue, renamed
// output handshake, commit and flush.
interface rename_map_table_if;
    import rename_map_table_pkg::*;

    logic  Valid_IN;
    logic  Ready_OUT;
    arch_t SrcA_IN;
    arch_t SrcB_IN;
    arch_t Dest_IN;
    logic  HasDest_IN;
    logic  FreeDequeue_OUT;
    logic  FreeValid_IN;
    phys_t FreeReg_IN;
    logic  Valid_OUT;
    logic  Ready_IN;
    phys_t PhysSrcA_OUT;
    phys_t PhysSrcB_OUT;
    phys_t PhysDest_OUT;
    phys_t OldPhysDest_OUT;
    logic  HasDest_OUT;
    logic  Commit_IN;
    arch_t CommitArch_IN;
    phys_t CommitPhys_IN;
    logic  Flush_IN;

    modport slave (
        input  Valid_IN, SrcA_IN, SrcB_IN, Dest_IN, HasDest_IN,
        input  FreeValid_IN, FreeReg_IN, Ready_IN,
        input  Commit_IN, CommitArch_IN, CommitPhys_IN, Flush_IN,
        output Ready_OUT, FreeDequeue_OUT, Valid_OUT,
        output PhysSrcA_OUT, PhysSrcB_OUT, PhysDest_OUT, OldPhysDest_OUT, HasDest_OUT
    );

    modport master (
        output Valid_IN, SrcA_IN, SrcB_IN, Dest_IN, HasDest_IN,
        output FreeValid_IN, FreeReg_IN, Ready_IN,
        output Commit_IN, CommitArch_IN, CommitPhys_IN, Flush_IN,
        input  Ready_OUT, FreeDequeue_OUT, Valid_OUT,
        input  PhysSrcA_OUT, PhysSrcB_OUT, PhysDest_OUT, OldPhysDest_OUT, HasDest_OUT
    );
endinterface

// File: rtl/rename_alloc_fsm.sv
// Free-list dequeue handshake plus the staged destination register.
// state   | meaning
// NEED    | request one register from the free list this cycle
// PENDING | wait for the registered dequeue response; retry if empty
// HAVE    | staged register valid, waiting to be consumed by a rename
module rename_alloc_fsm
    import rename_map_table_pkg::*;
(
    input  logic  CLK,
    input  logic  RESET,
    input  logic  FreeValid_IN,
    input  phys_t FreeReg_IN,
    input  logic  Consume_IN,
    output logic  FreeDequeue_OUT,
    output logic  Have_OUT,
    output phys_t Staged_OUT,
    output logic  Running_OUT
);
    logic [1:0] state;
    logic       running;

    // running keeps every output low while reset is asserted
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_NEED;
            Staged_OUT <= '0;
            running    <= 1'b0;
        end else begin
            running <= 1'b1;
            case (state)
                ST_NEED:    if (running) state <= ST_PENDING;
                ST_PENDING: begin
                    if (FreeValid_IN) begin
                        Staged_OUT <= FreeReg_IN;
                        state      <= ST_HAVE;
                    end else begin
                        state <= ST_NEED;
                    end
                end
                ST_HAVE:    if (Consume_IN) state <= ST_NEED;
                default:    state <= ST_NEED;
            endcase
        end
    end

    assign FreeDequeue_OUT = running && (state == ST_NEED);
    assign Have_OUT        = (state == ST_HAVE);
    assign Running_OUT     = running;
endmodule

// File: rtl/rename_map_table.sv
// Rename stage: speculative and retirement maps, one rename per cycle.
// Optional macro ZERO_REG_EN pins arch reg 0 to phys reg 0.
module rename_map_table
    import rename_map_table_pkg::*;
(
    input logic               CLK,
    input logic               RESET,
    rename_map_table_if.slave rif
);
    phys_t spec_map [NUM_ARCH_REGS];
    phys_t ret_map  [NUM_ARCH_REGS];

    logic  has_dest, commit_en, fire, have, running;
    phys_t staged;
    logic  valid_q, has_dest_q;
    phys_t src_a_q, src_b_q, dest_q, old_dest_q;

`ifdef ZERO_REG_EN
    assign has_dest  = rif.HasDest_IN && (rif.Dest_IN != '0);
    assign commit_en = rif.Commit_IN && (rif.CommitArch_IN != '0);
`else
    assign has_dest  = rif.HasDest_IN;
    assign commit_en = rif.Commit_IN;
`endif

    assign rif.Ready_OUT = running && !rif.Flush_IN && (!valid_q || rif.Ready_IN)
                           && (!has_dest || have);
    assign fire          = rif.Valid_IN && rif.Ready_OUT;

    rename_alloc_fsm u_alloc (
        .CLK             (CLK),
        .RESET           (RESET),
        .FreeValid_IN    (rif.FreeValid_IN),
        .FreeReg_IN      (rif.FreeReg_IN),
        .Consume_IN      (fire && has_dest),
        .FreeDequeue_OUT (rif.FreeDequeue_OUT),
        .Have_OUT        (have),
        .Staged_OUT      (staged),
        .Running_OUT     (running)
    );

    // flush copies the retirement map with this cycle's commit folded in
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                spec_map[i] <= phys_t'(i);
                ret_map[i]  <= phys_t'(i);
            end
        end else begin
            if (commit_en) ret_map[rif.CommitArch_IN] <= rif.CommitPhys_IN;
            if (rif.Flush_IN) begin
                for (int i = 0; i < NUM_ARCH_REGS; i++)
                    spec_map[i] <= (commit_en && rif.CommitArch_IN == arch_t'(i))
                                   ? rif.CommitPhys_IN : ret_map[i];
            end else if (fire && has_dest) begin
                spec_map[rif.Dest_IN] <= staged;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid_q    <= 1'b0;
            has_dest_q <= 1'b0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dest_q     <= '0;
            old_dest_q <= '0;
        end else if (rif.Flush_IN) begin
            valid_q <= 1'b0;
        end else if (fire) begin
            valid_q    <= 1'b1;
            has_dest_q <= has_dest;
            src_a_q    <= spec_map[rif.SrcA_IN];
            src_b_q    <= spec_map[rif.SrcB_IN];
            dest_q     <= has_dest ? staged : '0;
            old_dest_q <= has_dest ? spec_map[rif.Dest_IN] : '0;
        end else if (rif.Ready_IN) begin
            valid_q <= 1'b0;
        end
    end

    assign rif.Valid_OUT       = valid_q;
    assign rif.HasDest_OUT     = has_dest_q;
    assign rif.PhysSrcA_OUT    = src_a_q;
    assign rif.PhysSrcB_OUT    = src_b_q;
    assign rif.PhysDest_OUT    = dest_q;
    assign rif.OldPhysDest_OUT = old_dest_q;
endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
- Register-rename stage: maps architectural source/destination registers to physical registers, one instruction per cycle.
- Allocates new destination registers by dequeuing from the physical-register free list (directly upstream).
- Outputs the previous mapping of each destination so commit can later return it to the free list.
- Keeps a speculative map and a retirement map; flush restores speculative from retirement.

Parameters:
- NUM_ARCH_REGS, 32, architectural registers; LOG_ARCH = $clog2(NUM_ARCH_REGS).
- NUM_PHYS_REGS, 64, physical registers; LOG_PHYS = $clog2(NUM_PHYS_REGS); must exceed NUM_ARCH_REGS.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- Valid_IN  in  1  decoded instruction present
- Ready_OUT  out  1  stage accepts instruction this cycle
- SrcA_IN, SrcB_IN  in  LOG_ARCH each  architectural sources
- Dest_IN  in  LOG_ARCH  architectural destination
- HasDest_IN  in  1  instruction writes Dest_IN
- FreeDequeue_OUT  out  1  dequeue request to free list
- FreeValid_IN  in  1  free list dequeue succeeded (registered, one cycle after request)
- FreeReg_IN  in  LOG_PHYS  dequeued physical register
- Valid_OUT  out  1  renamed instruction valid
- Ready_IN  in  1  downstream accepts
- PhysSrcA_OUT, PhysSrcB_OUT  out  LOG_PHYS each  renamed sources
- PhysDest_OUT  out  LOG_PHYS  newly allocated destination
- OldPhysDest_OUT  out  LOG_PHYS  prior mapping of Dest_IN
- HasDest_OUT  out  1  registered copy of HasDest_IN
- Commit_IN  in  1  retire one mapping
- CommitArch_IN  in  LOG_ARCH  retiring architectural register
- CommitPhys_IN  in  LOG_PHYS  retiring physical register
- Flush_IN  in  1  misprediction recovery

Behaviour:
- Reset (async, RESET=0):
  - Both maps are identity (arch i -> phys i).
  - Allocator state is NEED.
  - All outputs are 0.
  - The free list holds only regs NUM_ARCH_REGS..NUM_PHYS_REGS-1 after reset.
- Allocator FSM:
  - NEED: FreeDequeue_OUT=1 for exactly one cycle; go to PENDING.
  - PENDING: if FreeValid_IN, capture FreeReg_IN into the staged register and go to HAVE; otherwise go to NEED (retry).
  - HAVE: the staged register is available; go to NEED when consumed by a fire with HasDest_IN=1.
  - FreeDequeue_OUT is never asserted in PENDING or HAVE.
- Ready_OUT = !Flush_IN && (!Valid_OUT || Ready_IN) && (!HasDest_IN || state==HAVE). Fire = Valid_IN && Ready_OUT.
- Fire:
  - Output regs latch PhysSrcA/B from the speculative map (pre-update values).
  - PhysDest_OUT = staged register; OldPhysDest_OUT = specmap[Dest_IN]; HasDest_OUT latched.
  - If HasDest_IN, specmap[Dest_IN] <= staged register.
  - Latency: 1 cycle, registered outputs.
- Same-register source and destination: sources get the old mapping. The next instruction sees the new mapping, with no bypass needed.
- HasDest_IN=0: PhysDest_OUT and OldPhysDest_OUT are 0; no allocation; the staged register is untouched.
- Output hold: Valid_OUT && !Ready_IN keeps all outputs stable. Valid_OUT clears when consumed without a new fire.
- Commit: retmap[CommitArch_IN] <= CommitPhys_IN.
- Flush:
  - specmap <= retmap, including any same-cycle commit.
  - Valid_OUT <= 0; Ready_OUT = 0.
  - The staged register and FSM state are preserved, so no leak.
- Flush beats fire. Commit and rename update independent maps.

Optional Feature:
- Macro ZERO_REG_EN.
- When defined:
  - Arch reg 0 always maps to phys 0 in both maps.
  - HasDest_IN with Dest_IN=0 is treated as HasDest_IN=0: no allocation, HasDest_OUT=0.
  - Commits to arch 0 are ignored.
- When undefined: arch 0 is renamed like any other register.

Decomposition:
- Shared package/header: LOG_ARCH/LOG_PHYS widths and the allocator state encoding (NEED/PENDING/HAVE).
- The free list reuses the same LOG_PHYS definition.
- Sub-module rename_alloc_fsm: the free-list handshake plus the staged register, exposing Have_OUT, Staged_OUT and Consume_IN.

Test Plan:
- Reset, then idle 3 cycles: FreeDequeue_OUT pulses 1 cycle; bench returns FreeValid_IN=1, FreeReg_IN=32 -> state HAVE, no further requests.
- Fire Src=1,2 Dest=3 HasDest=1 (staged 32) -> next cycle PhysSrc=1,2, PhysDest=32, OldPhysDest=3; new FreeDequeue_OUT pulse. Then Src=3 -> PhysSrcA=32.
- Free list empty (FreeValid_IN=0 repeatedly) with HasDest=1 pending -> Ready_OUT=0; NEED/PENDING alternate; supply 40 -> fires with PhysDest=40.
- Ready_IN=0 for 4 cycles with Valid_OUT=1 -> outputs frozen, Ready_OUT=0; release -> next instruction accepted.
- Rename arch 5->33, 6->34; commit 5->33; Flush_IN -> specmap[5]=33, specmap[6]=6, Valid_OUT=0, staged register retained.
- ZERO_REG_EN: Dest=0 HasDest=1 -> no dequeue, HasDest_OUT=0, Src=0 reads 0.
